mips_load_store_unit: RTL and testbench

- Sits between the MIPS execute/memory pipeline stage and the word-addressed data memory.
- Converts byte-addressed load/store requests into word accesses: LB/LBU/LH/LHU/LW and SB/SH/SW.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Uses a valid/ready request handshake, a one-cycle response pulse, and flags misaligned or out-of-range accesses.

---
 rtl/mips_load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_mips_load_store_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit: turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW
// requests into accesses on a word-addressed data memory. Sub-word stores
// are done as read-modify-write, and loads are sign- or zero-extended.
module mips_load_store_unit #(
  parameter int MEM_WORDS  = 1024,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store_data,
  output logic        mem_write_signal,
  input  logic [31:0] mem_load_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [31:0] MemWords = 32'(MEM_WORDS);

  state_t      state_q, state_d;
  logic        reqWrite_q, reqWrite_d;
  logic [1:0]  reqSize_q, reqSize_d;
  logic        reqSigned_q, reqSigned_d;
  logic [31:0] reqAddr_q, reqAddr_d;
  logic [31:0] reqWdata_q, reqWdata_d;
  logic [31:0] merged_q, merged_d;
  logic [31:0] respRdata_q, respRdata_d;
  logic        respErr_q, respErr_d;

  logic        acceptErr;
  logic [1:0]  laneIdx;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] laneMask;
  logic [31:0] loadExt;
  logic [31:0] mergedWord;

  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;

  // Classify the incoming request: bad size, misaligned, or beyond the memory.
  always_comb begin
    acceptErr = 1'b0;
    if (req_size == 2'b11) acceptErr = 1'b1;
    if (req_size == 2'b01 && req_addr[0]) acceptErr = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) acceptErr = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MemWords) acceptErr = 1'b1;
  end

  // Locate the addressed byte/half lane in the word, then extract/extend it
  // for loads and splice the store data into it for sub-word stores.
  always_comb begin
    laneIdx = 2'b00;
    if (reqSize_q == 2'b00) begin
      laneIdx = BIG_ENDIAN ? (2'd3 - reqAddr_q[1:0]) : reqAddr_q[1:0];
    end else if (reqSize_q == 2'b01) begin
      laneIdx = BIG_ENDIAN ? (2'd2 - {reqAddr_q[1], 1'b0}) : {reqAddr_q[1], 1'b0};
    end
    shamt    = {laneIdx, 3'b000};
    shifted  = mem_load_data >> shamt;
    laneMask = ((reqSize_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    case (reqSize_q)
      2'b00:   loadExt = {{24{reqSigned_q & shifted[7]}}, shifted[7:0]};
      2'b01:   loadExt = {{16{reqSigned_q & shifted[15]}}, shifted[15:0]};
      default: loadExt = shifted;
    endcase
    mergedWord = (mem_load_data & ~laneMask) | ((reqWdata_q << shamt) & laneMask);
  end

  // Next-state logic and memory/handshake outputs for the access sequencer.
  always_comb begin
    state_d          = state_q;
    reqWrite_d       = reqWrite_q;
    reqSize_d        = reqSize_q;
    reqSigned_d      = reqSigned_q;
    reqAddr_d        = reqAddr_q;
    reqWdata_d       = reqWdata_q;
    merged_d         = merged_q;
    respRdata_d      = respRdata_q;
    respErr_d        = respErr_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_addr         = 32'h0;
    mem_store_data   = 32'h0;
    mem_write_signal = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          reqWrite_d  = req_write;
          reqSize_d   = req_size;
          reqSigned_d = req_signed;
          reqAddr_d   = req_addr;
          reqWdata_d  = req_wdata;
          if (acceptErr) begin
            respErr_d   = 1'b1;
            respRdata_d = 32'h0;
            state_d     = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        mem_addr = {2'b00, reqAddr_q[31:2]};
        if (!reqWrite_q) begin
          respRdata_d = loadExt;
          respErr_d   = 1'b0;
          state_d     = RESP;
        end else if (reqSize_q == 2'b10) begin
          mem_store_data   = reqWdata_q;
          mem_write_signal = 1'b1;
          respRdata_d      = 32'h0;
          respErr_d        = 1'b0;
          state_d          = RESP;
        end else begin
          merged_d = mergedWord;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        mem_addr         = {2'b00, reqAddr_q[31:2]};
        mem_store_data   = merged_q;
        mem_write_signal = 1'b1;
        respRdata_d      = 32'h0;
        respErr_d        = 1'b0;
        state_d          = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset arriving mid-request must not let the memory see a write
    // or the pipeline see a completion on that same edge.
    if (!reset) begin
      resp_valid       = 1'b0;
      mem_addr         = 32'h0;
      mem_store_data   = 32'h0;
      mem_write_signal = 1'b0;
    end
  end

  // State and request/response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      reqWrite_q  <= 1'b0;
      reqSize_q   <= 2'b00;
      reqSigned_q <= 1'b0;
      reqAddr_q   <= 32'h0;
      reqWdata_q  <= 32'h0;
      merged_q    <= 32'h0;
      respRdata_q <= 32'h0;
      respErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      reqWrite_q  <= reqWrite_d;
      reqSize_q   <= reqSize_d;
      reqSigned_q <= reqSigned_d;
      reqAddr_q   <= reqAddr_d;
      reqWdata_q  <= reqWdata_d;
      merged_q    <= merged_d;
      respRdata_q <= respRdata_d;
      respErr_q   <= respErr_d;
    end
  end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Self-checking bench for mips_load_store_unit. A word-array memory serves
// the DUT; a separate byte-array model predicts every result.
module tb_mips_load_store_unit;

  localparam int MEM_WORDS = 1024;
  localparam bit BIG       = 1'b1;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic        mem_write_signal;
  logic [31:0] mem_load_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] dmem     [0:MEM_WORDS-1];
  logic [7:0]  refBytes [0:4*MEM_WORDS-1];

  mips_load_store_unit #(.MEM_WORDS(MEM_WORDS), .BIG_ENDIAN(BIG)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
    .mem_write_signal(mem_write_signal), .mem_load_data(mem_load_data)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed data memory with combinational read, write on the edge.
  assign mem_load_data = (mem_addr < MEM_WORDS) ? dmem[mem_addr[9:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (mem_write_signal && mem_addr < MEM_WORDS) dmem[mem_addr[9:0]] <= mem_store_data;
  end

  // Safety net so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- reference model (byte-addressed) ----------------
  function automatic logic [31:0] refWord(input int w);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (BIG) v = (v << 8) | 32'(refBytes[4*w+i]);
      else     v = v | (32'(refBytes[4*w+i]) << (8*i));
    end
    return v;
  endfunction

  function automatic logic refErr(input logic [1:0] sz, input logic [31:0] ad);
    int n = 1 << sz;
    if (sz == 2'b11) return 1'b1;
    if ((ad % n) != 0) return 1'b1;
    if ((ad >> 2) >= MEM_WORDS) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic sg, input logic [31:0] ad);
    int n = 1 << sz;
    logic [31:0] v = 32'h0;
    logic [31:0] keep;
    for (int i = 0; i < n; i++) begin
      if (BIG) v = (v << 8) | 32'(refBytes[int'(ad)+i]);
      else     v = v | (32'(refBytes[int'(ad)+i]) << (8*i));
    end
    if (n < 4) begin
      keep = (32'h1 << (8*n)) - 32'h1;
      if (sg && v[8*n-1]) v = v | ~keep;
    end
    return v;
  endfunction

  task automatic refStore(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    int n = 1 << sz;
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = BIG ? (wd >> (8*(n-1-i))) : (wd >> (8*i));
      refBytes[int'(ad)+i] = t[7:0];
    end
  endtask

  task automatic initMemory();
    logic [31:0] word;
    logic [31:0] t;
    for (int w = 0; w < MEM_WORDS; w++) begin
      word = (w == 3) ? 32'hEAC1_FA7A : $urandom;
      dmem[w] = word;
      for (int i = 0; i < 4; i++) begin
        t = word >> (8*(BIG ? (3-i) : i));
        refBytes[4*w+i] = t[7:0];
      end
    end
  endtask

  // Issue one request and observe the transaction; no checking here.
  task automatic doReq(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output logic er,
                       output int nWrites, output logic [31:0] wAddr,
                       output logic [31:0] wData, output logic extraResp,
                       output logic readyBusy);
    int waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; rd = 32'h0; er = 1'b0; nWrites = 0; wAddr = 32'h0; wData = 32'h0;
    extraResp = 1'b0; readyBusy = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (req_ready) readyBusy = 1'b1;
      if (mem_write_signal) begin
        nWrites++;
        wAddr = mem_addr;
        wData = mem_store_data;
      end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    extraResp = resp_valid;
    if (mem_write_signal) nWrites++;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp_err: got %b want 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_resp_rdata: got %h want 0", resp_rdata); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_store_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_store_data: got %h want 0", mem_store_data); end
    checks++; if (mem_write_signal !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_write: got %b want 0", mem_write_signal); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    logic [31:0] addrs [4] = '{32'd12, 32'd13, 32'd14, 32'd12};
    logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic        sgns  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exps  [4] = '{32'hFFFF_FFEA, 32'h0000_00C1, 32'hFFFF_FA7A, 32'hEAC1_FA7A};
    int lat, nw; logic [31:0] rd, wa, wdt; logic er, ex, rb;
    for (int i = 0; i < 4; i++) begin
      doReq(1'b0, sizes[i], sgns[i], addrs[i], $urandom, lat, rd, er, nw, wa, wdt, ex, rb);
      checks++; if (rd !== exps[i]) begin failures++; $display("[TB] FAIL load_rdata[%0d]: got %h want %h", i, rd, exps[i]); end
      checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL load_err[%0d]: got %b want 0", i, er); end
      checks++; if (lat != 2) begin failures++; $display("[TB] FAIL load_latency[%0d]: got %0d want 2", i, lat); end
      checks++; if (nw != 0) begin failures++; $display("[TB] FAIL load_writes[%0d]: got %0d want 0", i, nw); end
      checks++; if (rb !== 1'b0) begin failures++; $display("[TB] FAIL load_ready_busy[%0d]: got %b want 0", i, rb); end
    end
  endtask

  task automatic test_stores();
    int lat, nw; logic [31:0] rd, wa, wdt; logic er, ex, rb;
    doReq(1'b1, 2'b00, 1'b0, 32'd13, 32'h0000_0055, lat, rd, er, nw, wa, wdt, ex, rb);
    refStore(2'b00, 32'd13, 32'h0000_0055);
    checks++; if (nw != 1) begin failures++; $display("[TB] FAIL sb_writes: got %0d want 1", nw); end
    checks++; if (wa !== 32'd3) begin failures++; $display("[TB] FAIL sb_addr: got %h want 3", wa); end
    checks++; if (wdt !== 32'hEA55_FA7A) begin failures++; $display("[TB] FAIL sb_data: got %h want EA55FA7A", wdt); end
    checks++; if (lat != 3) begin failures++; $display("[TB] FAIL sb_latency: got %0d want 3", lat); end
    checks++; if (ex !== 1'b0) begin failures++; $display("[TB] FAIL sb_extra_resp: got %b want 0", ex); end
    doReq(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, lat, rd, er, nw, wa, wdt, ex, rb);
    checks++; if (rd !== 32'hEA55_FA7A) begin failures++; $display("[TB] FAIL sb_readback: got %h want EA55FA7A", rd); end
    doReq(1'b1, 2'b10, 1'b0, 32'd40, 32'h1234_5678, lat, rd, er, nw, wa, wdt, ex, rb);
    refStore(2'b10, 32'd40, 32'h1234_5678);
    checks++; if (nw != 1) begin failures++; $display("[TB] FAIL sw_writes: got %0d want 1", nw); end
    checks++; if (wa !== 32'd10) begin failures++; $display("[TB] FAIL sw_addr: got %h want A", wa); end
    checks++; if (wdt !== 32'h1234_5678) begin failures++; $display("[TB] FAIL sw_data: got %h want 12345678", wdt); end
    checks++; if (lat != 2) begin failures++; $display("[TB] FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL sw_rdata: got %h want 0", rd); end
    doReq(1'b0, 2'b10, 1'b0, 32'd40, 32'h0, lat, rd, er, nw, wa, wdt, ex, rb);
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("[TB] FAIL sw_readback: got %h want 12345678", rd); end
  endtask

  task automatic test_errors();
    logic        wrs   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] addrs [4] = '{32'd6, 32'd9, 32'd32, 32'd4096};
    int lat, nw; logic [31:0] rd, wa, wdt; logic er, ex, rb;
    for (int i = 0; i < 4; i++) begin
      doReq(wrs[i], sizes[i], 1'b1, addrs[i], $urandom, lat, rd, er, nw, wa, wdt, ex, rb);
      checks++; if (er !== 1'b1) begin failures++; $display("[TB] FAIL err_flag[%0d]: got %b want 1", i, er); end
      checks++; if (lat != 1) begin failures++; $display("[TB] FAIL err_latency[%0d]: got %0d want 1", i, lat); end
      checks++; if (nw != 0) begin failures++; $display("[TB] FAIL err_writes[%0d]: got %0d want 0", i, nw); end
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL err_rdata[%0d]: got %h want 0", i, rd); end
      checks++; if (ex !== 1'b0) begin failures++; $display("[TB] FAIL err_extra_resp[%0d]: got %b want 0", i, ex); end
    end
  endtask

  task automatic test_reset_during_write();
    int lat, nw, seen; logic [31:0] rd, wa, wdt; logic er, ex, rb;
    doReq(1'b0, 2'b10, 1'b0, 32'd12, 32'h0, lat, rd, er, nw, wa, wdt, ex, rb);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd21; req_wdata = 32'h0000_00A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (mem_write_signal !== 1'b0) begin failures++; $display("[TB] FAIL rst_wr_write: got %b want 0", mem_write_signal); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_wr_resp: got %b want 0", resp_valid); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_wr_ready: got %b want 1", req_ready); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_wr_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_wr_err: got %b want 0", resp_err); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL rst_wr_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_store_data !== 32'h0) begin failures++; $display("[TB] FAIL rst_wr_mem_data: got %h want 0", mem_store_data); end
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid || mem_write_signal) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin failures++; $display("[TB] FAIL rst_wr_after: got %0d activity cycles want 0", seen); end
    checks++; if (dmem[5] !== refWord(5)) begin failures++; $display("[TB] FAIL rst_wr_mem_word: got %h want %h", dmem[5], refWord(5)); end
  endtask

  task automatic test_random();
    int lat, nw, expLat, expNw, pick;
    logic [31:0] rd, wa, wdt, ad, wd, expRd;
    logic er, ex, rb, wr, sg, expEr;
    logic [1:0] sz;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 9);
      sz = (pick < 3) ? 2'b00 : (pick < 6) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
      ad = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(4096, 9000)) : 32'($urandom_range(0, 63));
      wd = $urandom;
      expEr = refErr(sz, ad);
      expRd = 32'h0; expNw = 0;
      if (expEr) expLat = 1;
      else if (!wr) begin expLat = 2; expRd = refLoad(sz, sg, ad); end
      else begin
        expLat = (sz == 2'b10) ? 2 : 3;
        expNw = 1;
        refStore(sz, ad, wd);
      end
      doReq(wr, sz, sg, ad, wd, lat, rd, er, nw, wa, wdt, ex, rb);
      checks++; if (rd !== expRd) begin failures++; $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", t, rd, expRd); end
      checks++; if (er !== expEr) begin failures++; $display("[TB] FAIL rand_err[%0d]: got %b want %b", t, er, expEr); end
      checks++; if (lat != expLat) begin failures++; $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", t, lat, expLat); end
      checks++; if (nw != expNw) begin failures++; $display("[TB] FAIL rand_writes[%0d]: got %0d want %0d", t, nw, expNw); end
      if (expNw == 1) begin
        checks++; if (wa !== (ad >> 2)) begin failures++; $display("[TB] FAIL rand_waddr[%0d]: got %h want %h", t, wa, ad >> 2); end
        checks++; if (wdt !== refWord(int'(ad >> 2))) begin failures++; $display("[TB] FAIL rand_wdata[%0d]: got %h want %h", t, wdt, refWord(int'(ad >> 2))); end
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    logic        bWr [N];
    logic [1:0]  bSz [N];
    logic        bSg [N];
    logic [31:0] bAd [N];
    logic [31:0] bWd [N];
    int idx = 0, respCount = 0, writesSeen = 0, expW = 0;
    logic outstanding = 1'b0, acceptedNow;
    logic [31:0] expRd = 32'h0;
    for (int i = 0; i < N; i++) begin
      bWr[i] = 1'(i % 2);
      bSz[i] = 2'($urandom_range(0, 2));
      bSg[i] = 1'($urandom_range(0, 1));
      bAd[i] = 32'(64 + 4 * $urandom_range(0, 7));
      if (bSz[i] == 2'b00) bAd[i] = bAd[i] + 32'($urandom_range(0, 3));
      if (bSz[i] == 2'b01) bAd[i] = bAd[i] + 32'(2 * $urandom_range(0, 1));
      bWd[i] = $urandom;
    end
    req_valid = 1'b1; req_write = bWr[0]; req_size = bSz[0]; req_signed = bSg[0];
    req_addr = bAd[0]; req_wdata = bWd[0];
    for (int cyc = 0; cyc < 200 && respCount < N; cyc++) begin
      acceptedNow = 1'b0;
      checks++; if (req_ready !== !outstanding) begin failures++; $display("[TB] FAIL b2b_ready[cyc %0d]: got %b want %b", cyc, req_ready, !outstanding); end
      if (mem_write_signal) writesSeen++;
      if (resp_valid) begin
        checks++; if (!outstanding) begin failures++; $display("[TB] FAIL b2b_spurious_resp[cyc %0d]: got 1 want 0", cyc); end
        checks++; if (resp_rdata !== expRd) begin failures++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", respCount, resp_rdata, expRd); end
        checks++; if (resp_err !== 1'b0) begin failures++; $display("[TB] FAIL b2b_err[%0d]: got %b want 0", respCount, resp_err); end
        checks++; if (writesSeen != expW) begin failures++; $display("[TB] FAIL b2b_writes[%0d]: got %0d want %0d", respCount, writesSeen, expW); end
        outstanding = 1'b0;
        respCount++;
      end else if (req_ready && idx < N) begin
        if (bWr[idx]) begin
          refStore(bSz[idx], bAd[idx], bWd[idx]);
          expRd = 32'h0; expW = 1;
        end else begin
          expRd = refLoad(bSz[idx], bSg[idx], bAd[idx]); expW = 0;
        end
        outstanding = 1'b1;
        writesSeen = 0;
        idx++;
        acceptedNow = 1'b1;
      end
      @(posedge clk); #1;
      if (acceptedNow) begin
        if (idx < N) begin
          req_write = bWr[idx]; req_size = bSz[idx]; req_signed = bSg[idx];
          req_addr = bAd[idx]; req_wdata = bWd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    checks++; if (respCount != N) begin failures++; $display("[TB] FAIL b2b_count: got %0d want %0d", respCount, N); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    initMemory();
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_during_write();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
